// File: rtl/pulse_to_level_pkg.sv
// Shared types, limits and helpers for the pulse_to_level block.
package pulse_to_level_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StHold = 2'd1;
  localparam state_t StGap  = 2'd2;

  localparam int unsigned MIN_CNT_W = 1;
  localparam int unsigned MAX_CNT_W = 32;

  // A phase of N cycles starts with the counter at N-1 and ends when it reads zero.
  function automatic int unsigned reload_val(input int unsigned cycles);
    if (cycles == 0) begin
      return 0;
    end
    return cycles - 1;
  endfunction

endpackage

// File: rtl/ptl_down_counter.sv
// Loadable saturating down-counter with a zero flag; load wins over enable.
module ptl_down_counter
  import pulse_to_level_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - One;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_to_level.sv
// Stretches one-cycle event pulses into fixed-length levels with a minimum low gap and a
// one-deep event queue. Define PULSE_TO_LEVEL_RETRIGGER_EN to make pulses during HOLD restart it.
module pulse_to_level
  import pulse_to_level_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic pulse,
  input  logic clr,
  output logic out,
  output logic busy,
  output logic pending,
  output logic drop
);

  localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;

  generate
    if ((CNT_W < MIN_CNT_W) || (CNT_W > MAX_CNT_W) || (HOLD_CYCLES < 1) ||
        (longint'(HOLD_CYCLES) > CntMax) || (longint'(GAP_CYCLES) > CntMax)) begin : g_bad_params
      $error("pulse_to_level: HOLD_CYCLES/GAP_CYCLES/CNT_W out of range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(reload_val(HOLD_CYCLES));
  localparam logic [CNT_W-1:0] GapLoad  = CNT_W'(reload_val(GAP_CYCLES));
  localparam bit               HasGap   = (GAP_CYCLES != 0);

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic             drop_q, drop_d;
  logic             out_q, busy_q;
  logic             cnt_load, cnt_en, cnt_zero, queue_pulse;
  logic [CNT_W-1:0] cnt_load_val;

  ptl_down_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (CLK),
    .rst_n   (RST),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .en      (cnt_en),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    drop_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    queue_pulse  = 1'b0;

    if (clr) begin
      state_d   = StIdle;
      pending_d = 1'b0;
      cnt_load  = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (pulse) begin
            state_d      = StHold;
            cnt_load     = 1'b1;
            cnt_load_val = HoldLoad;
          end
        end
        StHold: begin
`ifdef PULSE_TO_LEVEL_RETRIGGER_EN
          if (pulse) begin
            cnt_load     = 1'b1;
            cnt_load_val = HoldLoad;
          end else if (!cnt_zero) begin
            cnt_en = 1'b1;
          end else if (HasGap) begin
            state_d      = StGap;
            cnt_load     = 1'b1;
            cnt_load_val = GapLoad;
          end else if (pending_q) begin
            cnt_load     = 1'b1;
            cnt_load_val = HoldLoad;
            pending_d    = 1'b0;
          end else begin
            state_d = StIdle;
          end
`else
          if (!cnt_zero) begin
            cnt_en      = 1'b1;
            queue_pulse = pulse;
          end else if (HasGap) begin
            // A pulse in the last hold cycle is queued, not merged.
            state_d      = StGap;
            cnt_load     = 1'b1;
            cnt_load_val = GapLoad;
            queue_pulse  = pulse;
          end else if (pending_q || pulse) begin
            cnt_load     = 1'b1;
            cnt_load_val = HoldLoad;
            pending_d    = pending_q & pulse;
          end else begin
            state_d = StIdle;
          end
`endif
        end
        StGap: begin
          if (!cnt_zero) begin
            cnt_en      = 1'b1;
            queue_pulse = pulse;
          end else if (pending_q || pulse) begin
            // Queued event is consumed; a same-cycle pulse takes its place in the queue.
            state_d      = StHold;
            cnt_load     = 1'b1;
            cnt_load_val = HoldLoad;
            pending_d    = pending_q & pulse;
          end else begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase

      if (queue_pulse) begin
        if (pending_q) begin
          drop_d = 1'b1;
        end else begin
          pending_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      out_q     <= (state_d == StHold);
      busy_q    <= (state_d != StIdle);
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign pending = pending_q;
  assign drop    = drop_q;

endmodule

// File: tb/tb_pulse_to_level.sv
// Directed bench for pulse_to_level with HOLD_CYCLES=4, GAP_CYCLES=2.
module tb_pulse_to_level;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic pulse = 1'b0;
  logic clr = 1'b0;
  logic out, busy, pending, drop;

  int tests = 0;
  int fails = 0;

  pulse_to_level #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2),
    .CNT_W      (8)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .pulse  (pulse),
    .clr    (clr),
    .out    (out),
    .busy   (busy),
    .pending(pending),
    .drop   (drop)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Bit i of each vector: inputs in cycle i (rv=1 means RST low), expected outputs in cycle i+1.
  task automatic run_seq(input string tag, input int n,
                         input logic [15:0] pv, input logic [15:0] cv, input logic [15:0] rv,
                         input logic [15:0] eo, input logic [15:0] eb,
                         input logic [15:0] ep, input logic [15:0] ed);
    for (int i = 0; i < n; i++) begin
      pulse = pv[i];
      clr   = cv[i];
      RST   = ~rv[i];
      @(posedge CLK);
      #1;
      pulse = 1'b0;
      clr   = 1'b0;
      RST   = 1'b1;
      chk($sformatf("%s out c%0d", tag, i + 1), out, eo[i]);
      chk($sformatf("%s busy c%0d", tag, i + 1), busy, eb[i]);
      chk($sformatf("%s pending c%0d", tag, i + 1), pending, ep[i]);
      chk($sformatf("%s drop c%0d", tag, i + 1), drop, ed[i]);
    end
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("reset out", out, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset pending", pending, 1'b0);
    chk("reset drop", drop, 1'b0);
    RST = 1'b1;

    // Single pulse at c0, then a new pulse accepted at c7 right after returning to idle.
    run_seq("single", 14, 16'h0081, 16'h0000, 16'h0000,
            16'h078F, 16'h1FBF, 16'h0000, 16'h0000);

`ifdef PULSE_TO_LEVEL_RETRIGGER_EN
    // Pulse at c2 restarts the hold: out c1..c6, gap c7..c8, idle c9.
    run_seq("retrig", 10, 16'h0005, 16'h0000, 16'h0000,
            16'h003F, 16'h00FF, 16'h0000, 16'h0000);
`else
    // Pulse at c2 is queued and replayed after the gap.
    run_seq("queue", 14, 16'h0005, 16'h0000, 16'h0000,
            16'h03CF, 16'h0FFF, 16'h003C, 16'h0000);
    // Third pulse at c3 overflows the queue.
    run_seq("drop", 14, 16'h000D, 16'h0000, 16'h0000,
            16'h03CF, 16'h0FFF, 16'h003C, 16'h0008);
`endif

    // Reset in c2 aborts the hold and discards the pulse queued at c1; pulse at c3 restarts.
`ifdef PULSE_TO_LEVEL_RETRIGGER_EN
    run_seq("rst", 10, 16'h000B, 16'h0000, 16'h0004,
            16'h007B, 16'h01FB, 16'h0000, 16'h0000);
`else
    run_seq("rst", 10, 16'h000B, 16'h0000, 16'h0004,
            16'h007B, 16'h01FB, 16'h0002, 16'h0000);
`endif

    // clr+pulse at c0 ignored; hold from c3, clr at c4 ends it and flushes the c3 queue entry.
`ifdef PULSE_TO_LEVEL_RETRIGGER_EN
    run_seq("clr", 8, 16'h000D, 16'h0011, 16'h0000,
            16'h000C, 16'h000C, 16'h0000, 16'h0000);
`else
    run_seq("clr", 8, 16'h000D, 16'h0011, 16'h0000,
            16'h000C, 16'h000C, 16'h0008, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
